wts_envelope_context_sequencer: RTL and testbench

- Owns the per-channel ADSR envelope context (counter, state, level) for all wave-table channels.
- Time-multiplexes one combinational envelope kernel across the channels: presents one channel's stored context per slot and writes back the kernel's next-context results.
- Converts asynchronous-to-slot key requests from the register interface into single-cycle key_on / key_release / key_off pulses aligned to that channel's slot.
- Sits between the CPU register block and the envelope kernel.

---
 rtl/wts_eg_pkg.sv | 30 +++
 rtl/wts_envelope_context_sequencer_if.sv | 29 ++
 rtl/wts_eg_key_pending.sv | 41 ++++
 rtl/wts_envelope_context_sequencer.sv | 92 +++++++++
 tb/tb_wts_envelope_context_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/wts_eg_pkg.sv
// Shared encodings and widths for the wave-table envelope context sequencer.
package wts_eg_pkg;
    localparam int COUNTER_W = 16;
    localparam int STATE_W   = 3;
    localparam int LEVEL_W   = 7;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 7'd64;

    typedef enum logic [STATE_W-1:0] {
        EG_IDLE    = 3'd0,
        EG_ATTACK  = 3'd1,
        EG_DECAY   = 3'd2,
        EG_SUSTAIN = 3'd3,
        EG_RELEASE = 3'd4
    } eg_state_e;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_ON   = 2'd1,
        PEND_REL  = 2'd2,
        PEND_OFF  = 2'd3
    } pend_e;

    // Simultaneous requests resolve OFF > ON > REL.
    function automatic pend_e req_to_code(input logic on, input logic rel, input logic off);
        if (off)      return PEND_OFF;
        else if (on)  return PEND_ON;
        else if (rel) return PEND_REL;
        else          return PEND_NONE;
    endfunction
endpackage

// File: rtl/wts_envelope_context_sequencer_if.sv
// Bus between the context sequencer (master) and the combinational envelope kernel (slave).
interface wts_envelope_context_sequencer_if #(
    parameter int CH_BITS = 3
);
    import wts_eg_pkg::*;

    logic [CH_BITS-1:0]   slot_ch;
    logic                 key_on;
    logic                 key_release;
    logic                 key_off;
    logic [COUNTER_W-1:0] eg_counter;
    logic [STATE_W-1:0]   eg_state;
    logic [LEVEL_W-1:0]   eg_level;
    logic [COUNTER_W-1:0] eg_counter_next;
    logic [STATE_W-1:0]   eg_state_next;
    logic [LEVEL_W-1:0]   eg_level_next;

    modport master (
        output slot_ch, key_on, key_release, key_off,
        output eg_counter, eg_state, eg_level,
        input  eg_counter_next, eg_state_next, eg_level_next
    );

    modport slave (
        input  slot_ch, key_on, key_release, key_off,
        input  eg_counter, eg_state, eg_level,
        output eg_counter_next, eg_state_next, eg_level_next
    );
endinterface

// File: rtl/wts_eg_key_pending.sv
// Per-channel pending key codes; a code waits until its channel's slot is ticked.
module wts_eg_key_pending
    import wts_eg_pkg::*;
#(
    parameter int NUM_CH  = 6,
    parameter int CH_BITS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CH_BITS-1:0] i_req_ch,
    input  logic               i_req_key_on,
    input  logic               i_req_key_release,
    input  logic               i_req_key_off,
    input  logic               i_eg_tick,
    input  logic [CH_BITS-1:0] i_slot_ch,
    output pend_e              o_slot_code
);
    localparam logic [CH_BITS:0] LP_NUM_CH = (CH_BITS+1)'(NUM_CH);

    pend_e r_pend [NUM_CH];
    pend_e w_req_code;
    logic  w_req_vld;

    assign w_req_code = req_to_code(i_req_key_on, i_req_key_release, i_req_key_off);
    assign w_req_vld  = (w_req_code != PEND_NONE) && ({1'b0, i_req_ch} < LP_NUM_CH);

    // A new request beats the clear, so a request landing on its own slot's tick waits a full round.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NUM_CH; n++) begin
            if (reset) begin
                r_pend[n] <= PEND_NONE;
            end else if (w_req_vld && (i_req_ch == CH_BITS'(n))) begin
                r_pend[n] <= w_req_code;
            end else if (i_eg_tick && (i_slot_ch == CH_BITS'(n))) begin
                r_pend[n] <= PEND_NONE;
            end
        end
    end

    assign o_slot_code = r_pend[i_slot_ch];
endmodule

// File: rtl/wts_envelope_context_sequencer.sv
// Time-multiplexes the envelope kernel across channels and owns their contexts.
// Optional readback mux built when WTS_EG_READBACK_EN is defined.
module wts_envelope_context_sequencer
    import wts_eg_pkg::*;
#(
    parameter int NUM_CH  = 6,
    parameter int CH_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CH_BITS-1:0]   i_req_ch,
    input  logic                 i_req_key_on,
    input  logic                 i_req_key_release,
    input  logic                 i_req_key_off,
    input  logic                 i_eg_tick,
    wts_envelope_context_sequencer_if.master kern_if,
    output logic [NUM_CH-1:0]    o_ch_active,
    input  logic [CH_BITS-1:0]   i_rd_ch,
    output logic [LEVEL_W-1:0]   o_rd_level,
    output logic [STATE_W-1:0]   o_rd_state
);
    localparam logic [CH_BITS-1:0] LP_LAST_CH = CH_BITS'(NUM_CH - 1);

    logic [CH_BITS-1:0]   r_slot_ch;
    logic [COUNTER_W-1:0] r_ctx_counter [NUM_CH];
    logic [STATE_W-1:0]   r_ctx_state   [NUM_CH];
    logic [LEVEL_W-1:0]   r_ctx_level   [NUM_CH];
    logic [NUM_CH-1:0]    r_ch_active;
    pend_e                w_slot_code;

    wts_eg_key_pending #(
        .NUM_CH  (NUM_CH),
        .CH_BITS (CH_BITS)
    ) u_key_pending (
        .clk               (clk),
        .reset             (reset),
        .i_req_ch          (i_req_ch),
        .i_req_key_on      (i_req_key_on),
        .i_req_key_release (i_req_key_release),
        .i_req_key_off     (i_req_key_off),
        .i_eg_tick         (i_eg_tick),
        .i_slot_ch         (r_slot_ch),
        .o_slot_code       (w_slot_code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_ch   <= '0;
            r_ch_active <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                r_ctx_counter[n] <= '0;
                r_ctx_state[n]   <= '0;
                r_ctx_level[n]   <= '0;
            end
        end else begin
            if (i_eg_tick) begin
                r_ctx_counter[r_slot_ch] <= kern_if.eg_counter_next;
                r_ctx_state[r_slot_ch]   <= kern_if.eg_state_next;
                r_ctx_level[r_slot_ch]   <= kern_if.eg_level_next;
                r_slot_ch <= (r_slot_ch == LP_LAST_CH) ? '0 : r_slot_ch + 1'b1;
            end
            // Deliberately one cycle behind the context write-back.
            for (int n = 0; n < NUM_CH; n++) begin
                r_ch_active[n] <= (r_ctx_state[n] != '0);
            end
        end
    end

    assign kern_if.slot_ch     = r_slot_ch;
    assign kern_if.eg_counter  = r_ctx_counter[r_slot_ch];
    assign kern_if.eg_state    = r_ctx_state[r_slot_ch];
    assign kern_if.eg_level    = r_ctx_level[r_slot_ch];
    assign kern_if.key_on      = i_eg_tick && (w_slot_code == PEND_ON);
    assign kern_if.key_release = i_eg_tick && (w_slot_code == PEND_REL);
    assign kern_if.key_off     = i_eg_tick && (w_slot_code == PEND_OFF);
    assign o_ch_active         = r_ch_active;

`ifdef WTS_EG_READBACK_EN
    localparam logic [CH_BITS:0] LP_NUM_CH = (CH_BITS+1)'(NUM_CH);
    logic w_rd_vld;

    assign w_rd_vld   = ({1'b0, i_rd_ch} < LP_NUM_CH);
    assign o_rd_level = w_rd_vld ? r_ctx_level[i_rd_ch] : '0;
    assign o_rd_state = w_rd_vld ? r_ctx_state[i_rd_ch] : '0;
`else
    logic w_unused_rd_ch;

    assign w_unused_rd_ch = ^i_rd_ch;
    assign o_rd_level     = '0;
    assign o_rd_state     = '0;
`endif
endmodule

// File: tb/tb_wts_envelope_context_sequencer.sv
// Scoreboard bench: each tick pushes its hand-computed expectation; a monitor checks ticks as they occur.
module tb_wts_envelope_context_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req_ch = '0;
    logic       req_on = 1'b0, req_rel = 1'b0, req_off = 1'b0;
    logic       eg_tick = 1'b0;
    logic [5:0] ch_active;
    logic [2:0] rd_ch = '0;
    logic [6:0] rd_level;
    logic [2:0] rd_state;
    logic       force_lv = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [2:0]  slot;
        logic        kon;
        logic        krel;
        logic        koff;
        logic [15:0] cnt;
        logic [2:0]  st;
        logic [6:0]  lv;
        logic [5:0]  act;
    } exp_t;

    exp_t exp_q[$];

    wts_envelope_context_sequencer_if #(.CH_BITS(3)) kif ();

    wts_envelope_context_sequencer #(.NUM_CH(6), .CH_BITS(3)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_req_ch          (req_ch),
        .i_req_key_on      (req_on),
        .i_req_key_release (req_rel),
        .i_req_key_off     (req_off),
        .i_eg_tick         (eg_tick),
        .kern_if           (kif),
        .o_ch_active       (ch_active),
        .i_rd_ch           (rd_ch),
        .o_rd_level        (rd_level),
        .o_rd_state        (rd_state)
    );

    always #5 clk = ~clk;

    // Kernel stand-in: on -> ATTACK/A5A5/10, off -> all zero, release -> RELEASE, else hold.
    always_comb begin
        kif.eg_counter_next = kif.eg_counter;
        kif.eg_state_next   = kif.eg_state;
        kif.eg_level_next   = kif.eg_level;
        if (kif.key_off) begin
            kif.eg_counter_next = '0;
            kif.eg_state_next   = '0;
            kif.eg_level_next   = '0;
        end else if (kif.key_on) begin
            kif.eg_counter_next = 16'hA5A5;
            kif.eg_state_next   = 3'd1;
            kif.eg_level_next   = 7'd10;
        end else if (kif.key_release) begin
            kif.eg_state_next   = 3'd4;
        end
        if (force_lv && kif.slot_ch == 3'd5) kif.eg_level_next = 7'd40;
    end

    always @(negedge clk) begin
        exp_t got, e;
        if (!reset) begin
            got = {kif.slot_ch, kif.key_on, kif.key_release, kif.key_off,
                   kif.eg_counter, kif.eg_state, kif.eg_level, ch_active};
            vectors++;
            if (eg_tick) begin
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL tick_unexpected: got %h, no expectation queued", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        miscompares++;
                        $display("FAIL tick slot=%0d: got slot=%0d k=%b%b%b cnt=%h st=%0d lv=%0d act=%b, expected slot=%0d k=%b%b%b cnt=%h st=%0d lv=%0d act=%b",
                                 e.slot, got.slot, got.kon, got.krel, got.koff, got.cnt, got.st, got.lv, got.act,
                                 e.slot, e.kon, e.krel, e.koff, e.cnt, e.st, e.lv, e.act);
                    end
                end
            end else if ({kif.key_on, kif.key_release, kif.key_off} !== 3'b000) begin
                miscompares++;
                $display("FAIL key_without_tick: got %b expected 000",
                         {kif.key_on, kif.key_release, kif.key_off});
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] ch, input logic on, input logic rel, input logic off);
        req_ch = ch; req_on = on; req_rel = rel; req_off = off;
        idle();
        req_on = 1'b0; req_rel = 1'b0; req_off = 1'b0;
    endtask

    // Any request set up by the caller is presented in the same cycle as the tick.
    task automatic tick(input logic [2:0] s, input logic [2:0] keys, input logic [15:0] cnt,
                        input logic [2:0] st, input logic [6:0] lv, input logic [5:0] act);
        exp_t e;
        e = {s, keys, cnt, st, lv, act};
        exp_q.push_back(e);
        eg_tick = 1'b1;
        idle();
        eg_tick = 1'b0;
        req_on = 1'b0; req_rel = 1'b0; req_off = 1'b0;
        idle();
    endtask

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    localparam logic [2:0] K_NONE = 3'b000, K_ON = 3'b100, K_OFF = 3'b001;

    initial begin
        logic [6:0] exp_rd40;
        logic [2:0] exp_rd_st1;
`ifdef WTS_EG_READBACK_EN
        exp_rd40 = 7'd40; exp_rd_st1 = 3'd1;
`else
        exp_rd40 = 7'd0;  exp_rd_st1 = 3'd0;
`endif
        idle(); idle();
        reset = 1'b0;
        idle();
        chk("reset_slot", 32'(kif.slot_ch), 0);
        chk("reset_counter", 32'(kif.eg_counter), 0);
        chk("reset_state", 32'(kif.eg_state), 0);
        chk("reset_level", 32'(kif.eg_level), 0);
        chk("reset_active", 32'(ch_active), 0);
        chk("reset_rd_level", 32'(rd_level), 0);
        chk("reset_rd_state", 32'(rd_state), 0);

        // Idle round: slots 0..5 then wrap.
        for (int i = 0; i < 6; i++) tick(3'(i), K_NONE, 16'h0, 3'd0, 7'd0, 6'h00);
        chk("wrap_slot", 32'(kif.slot_ch), 0);

        // Key on ch2 issued at slot 0.
        req(3'd2, 1'b1, 1'b0, 1'b0);
        tick(3'd0, K_NONE, 16'h0, 3'd0, 7'd0, 6'h00);
        tick(3'd1, K_NONE, 16'h0, 3'd0, 7'd0, 6'h00);
        tick(3'd2, K_ON,   16'h0, 3'd0, 7'd0, 6'h00);
        tick(3'd3, K_NONE, 16'h0, 3'd0, 7'd0, 6'h04);
        tick(3'd4, K_NONE, 16'h0, 3'd0, 7'd0, 6'h04);
        tick(3'd5, K_NONE, 16'h0, 3'd0, 7'd0, 6'h04);
        tick(3'd0, K_NONE, 16'h0, 3'd0, 7'd0, 6'h04);
        tick(3'd1, K_NONE, 16'h0, 3'd0, 7'd0, 6'h04);
        tick(3'd2, K_NONE, 16'hA5A5, 3'd1, 7'd10, 6'h04);

        // ON then OFF to ch3: last request wins.
        req(3'd3, 1'b1, 1'b0, 1'b0);
        req(3'd3, 1'b0, 1'b0, 1'b1);
        tick(3'd3, K_OFF, 16'h0, 3'd0, 7'd0, 6'h04);

        // Request to ch1 coincident with slot 1's tick waits a full round.
        tick(3'd4, K_NONE, 16'h0, 3'd0, 7'd0, 6'h04);
        tick(3'd5, K_NONE, 16'h0, 3'd0, 7'd0, 6'h04);
        tick(3'd0, K_NONE, 16'h0, 3'd0, 7'd0, 6'h04);
        req_ch = 3'd1; req_on = 1'b1;
        tick(3'd1, K_NONE, 16'h0, 3'd0, 7'd0, 6'h04);
        tick(3'd2, K_NONE, 16'hA5A5, 3'd1, 7'd10, 6'h04);
        for (int i = 3; i < 6; i++) tick(3'(i), K_NONE, 16'h0, 3'd0, 7'd0, 6'h04);
        tick(3'd0, K_NONE, 16'h0, 3'd0, 7'd0, 6'h04);
        tick(3'd1, K_ON,   16'h0, 3'd0, 7'd0, 6'h04);

        // ON and RELEASE together on ch4: ON wins.
        req(3'd4, 1'b1, 1'b1, 1'b0);
        tick(3'd2, K_NONE, 16'hA5A5, 3'd1, 7'd10, 6'h06);
        tick(3'd3, K_NONE, 16'h0, 3'd0, 7'd0, 6'h06);
        tick(3'd4, K_ON,   16'h0, 3'd0, 7'd0, 6'h06);

        // Kernel drives ch5 level to 40.
        force_lv = 1'b1;
        tick(3'd5, K_NONE, 16'h0, 3'd0, 7'd0, 6'h16);
        force_lv = 1'b0;
        rd_ch = 3'd5; #1;
        chk("rd_level_ch5", 32'(rd_level), 32'(exp_rd40));
        rd_ch = 3'd2; #1;
        chk("rd_state_ch2", 32'(rd_state), 32'(exp_rd_st1));
        rd_ch = 3'd6; #1;
        chk("rd_level_out_of_range", 32'(rd_level), 0);
        rd_ch = 3'd5;

        // Mid-run reset with a pending ch0 request and a request in the reset cycle.
        req(3'd0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1; req_ch = 3'd1; req_on = 1'b1;
        idle();
        reset = 1'b0; req_on = 1'b0;
        chk("mreset_slot", 32'(kif.slot_ch), 0);
        chk("mreset_counter", 32'(kif.eg_counter), 0);
        chk("mreset_state", 32'(kif.eg_state), 0);
        chk("mreset_level", 32'(kif.eg_level), 0);
        chk("mreset_active", 32'(ch_active), 0);
        chk("mreset_rd_level", 32'(rd_level), 0);

        // Out-of-range channel request is ignored; nothing may pulse in the next round.
        req(3'd7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick(3'(i), K_NONE, 16'h0, 3'd0, 7'd0, 6'h00);

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
